// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_pkg;

   localparam int DIV_W = 64;
   localparam int CNT_W = $clog2(DIV_W);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W-1:0] r_i,
   input  logic         bit_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] r_o,
   output logic         qbit_o
);

   logic [W:0] t;

   // T needs W+1 bits; the result is always below divisor so fits W bits
   assign t = {r_i, bit_i};

   always_comb begin
      r_o    = t[W-1:0];
      qbit_o = 1'b0;
      if (t >= {1'b0, divisor_i}) begin
         r_o    = W'(t - {1'b0, divisor_i});
         qbit_o = 1'b1;
      end
   end

endmodule

// File: rtl/div128x64_seq.sv
// 2W/W sequential restoring divider, one quotient bit per cycle.
// Define DIV_STICKY_EN to add the sticky (remainder != 0) output.
module div128x64_seq
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder,
   output logic           err
`ifdef DIV_STICKY_EN
   ,
   output logic           sticky
`endif
);

   localparam int CW = $clog2(W);

   state_e state_q, state_d;

   logic [W-1:0]  r_q, r_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  step_r;
   logic          step_qb;
`ifdef DIV_STICKY_EN
   logic          sticky_q, sticky_d;
`endif

   div_step #(.W(W)) u_step (
      .r_i       (r_q),
      .bit_i     (sh_q[W-1]),
      .divisor_i (dvs_q),
      .r_o       (step_r),
      .qbit_o    (step_qb)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      sh_d    = sh_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef DIV_STICKY_EN
      sticky_d = sticky_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0 || dividend[2*W-1:W] >= divisor) begin
                  err_d   = 1'b1;
                  quo_d   = '1;
                  rem_d   = '0;
`ifdef DIV_STICKY_EN
                  sticky_d = 1'b0;
`endif
                  state_d = DONE;
               end else begin
                  r_d     = dividend[2*W-1:W];
                  sh_d    = dividend[W-1:0];
                  dvs_d   = divisor;
                  cnt_d   = CW'(W-1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // dividend bits leave at the top while quotient bits enter below
            r_d  = step_r;
            sh_d = {sh_q[W-2:0], step_qb};
            if (cnt_q == '0) begin
               quo_d   = {sh_q[W-2:0], step_qb};
               rem_d   = step_r;
               err_d   = 1'b0;
`ifdef DIV_STICKY_EN
               sticky_d = (step_r != '0);
`endif
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         r_q     <= '0;
         sh_q    <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef DIV_STICKY_EN
         sticky_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         sh_q    <= sh_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef DIV_STICKY_EN
         sticky_q <= sticky_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign err       = err_q;
`ifdef DIV_STICKY_EN
   assign sticky    = sticky_q;
`endif

endmodule

// File: tb/tb_div128x64_seq.sv
// Directed bench for div128x64_seq with a plain-arithmetic reference model.
module tb_div128x64_seq;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  dividend = '0;
   logic [63:0]   divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [63:0]   quotient;
   logic [63:0]   remainder;
   logic          err;
`ifdef DIV_STICKY_EN
   logic          sticky;
`endif

   int checks = 0;
   int errors = 0;

   bit           pend = 1'b0;
   logic [63:0]  exp_q, exp_r;
   logic         exp_e, exp_s;

   div128x64_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err)
`ifdef DIV_STICKY_EN
      ,
      .sticky    (sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [127:0] n, input logic [63:0] d,
                                 output logic [63:0] q, output logic [63:0] r,
                                 output logic e);
      logic [127:0] qq, rr;
      if (d == 64'd0 || n[127:64] >= d) begin
         q = '1;
         r = '0;
         e = 1'b1;
      end else begin
         qq = n / {64'd0, d};
         rr = n % {64'd0, d};
         q  = qq[63:0];
         r  = rr[63:0];
         e  = 1'b0;
      end
   endfunction

   // expectation captured at the accepting edge, retired on handshake
   always @(posedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (out_valid && out_ready) pend = 1'b0;
         if (in_valid && in_ready) begin
            model(dividend, divisor, exp_q, exp_r, exp_e);
            exp_s = !exp_e && (exp_r != 64'd0);
            pend  = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("result_expected", 128'(pend), 128'(1));
         if (pend) begin
            chk("mon_quotient", 128'(quotient), 128'(exp_q));
            chk("mon_remainder", 128'(remainder), 128'(exp_r));
            chk("mon_err", 128'(err), 128'(exp_e));
`ifdef DIV_STICKY_EN
            chk("mon_sticky", 128'(sticky), 128'(exp_s));
`endif
         end
      end
   end

   typedef struct {
      logic [127:0] n;
      logic [63:0]  d;
      logic [63:0]  q;
      logic [63:0]  r;
      logic         e;
   } vec_t;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   vec_t vecs [9] = '{
      '{128'd100, 64'd7, 64'd14, 64'd2, 1'b0},
      '{128'd5, 64'd0, ONES, 64'd0, 1'b1},
      '{{64'h1, 64'h0}, 64'd1, ONES, 64'd0, 1'b1},
      '{{64'hFFFF_FFFF_FFFF_FFFE, ONES}, ONES, ONES,
        64'hFFFF_FFFF_FFFF_FFFE, 1'b0},
      '{128'd98, 64'd7, 64'd14, 64'd0, 1'b0},
      '{{64'h1, 64'h0}, 64'd2, 64'h8000_0000_0000_0000, 64'd0, 1'b0},
      '{{64'h0, ONES}, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0},
      '{{64'h7, 64'h0}, 64'd7, ONES, 64'd0, 1'b1},
      '{{64'h6, ONES}, 64'd7, ONES, 64'd6, 1'b0}
   };

   task automatic start(input logic [127:0] n, input logic [63:0] d);
      @(negedge clk);
      chk("in_ready_before_start", 128'(in_ready), 128'(1));
      dividend = n;
      divisor  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = {$urandom, $urandom, $urandom, $urandom};
      divisor  = {$urandom, $urandom};
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 200);
      if (!out_valid) chk("timeout_out_valid", 128'(0), 128'(1));
   endtask

   int lat;
   int seen;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_quotient", 128'(quotient), 128'(0));
      chk("rst_remainder", 128'(remainder), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
`ifdef DIV_STICKY_EN
      chk("rst_sticky", 128'(sticky), 128'(0));
`endif
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         out_ready = 1'b1;
         start(vecs[i].n, vecs[i].d);
         wait_done(lat);
         chk("latency", 128'(lat), vecs[i].e ? 128'(1) : 128'(65));
         chk("vec_quotient", 128'(quotient), 128'(vecs[i].q));
         chk("vec_remainder", 128'(remainder), 128'(vecs[i].r));
         chk("vec_err", 128'(err), 128'(vecs[i].e));
`ifdef DIV_STICKY_EN
         chk("vec_sticky", 128'(sticky),
             128'(!vecs[i].e && vecs[i].r != 64'd0));
`endif
         @(negedge clk);
         chk("out_valid_drop", 128'(out_valid), 128'(0));
         chk("in_ready_after", 128'(in_ready), 128'(1));
         chk("hold_quotient", 128'(quotient), 128'(vecs[i].q));
      end

      // stall in DONE with competing operands presented
      out_ready = 1'b0;
      start(128'd1000, 64'd3);
      wait_done(lat);
      for (int k = 0; k < 10; k++) begin
         dividend = 128'd55;
         divisor  = 64'd5;
         in_valid = 1'b1;
         @(negedge clk);
         chk("stall_in_ready", 128'(in_ready), 128'(0));
         chk("stall_out_valid", 128'(out_valid), 128'(1));
         chk("stall_quotient", 128'(quotient), 128'(333));
         chk("stall_remainder", 128'(remainder), 128'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", 128'(out_valid), 128'(0));
      repeat (3) @(negedge clk);
      chk("stall_no_extra", 128'(in_ready), 128'(1));

      // reset while running discards the operation
      start({64'h0, 64'd12345}, 64'd10);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_quotient", 128'(quotient), 128'(0));
      chk("midrst_err", 128'(err), 128'(0));
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_stale", 128'(seen), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
